// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: Moore FSM that sequences start, data, optional parity and stop
// bits one per clock, driving the line-mux select and the current data/parity bits.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] PData,
    input  logic                  DataValid,
    input  logic                  ParEn,
    input  logic                  ParType,
    output logic [1:0]            MuxSelection,
    output logic                  SerData,
    output logic                  ParityBit,
    output logic                  Busy
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  data_par_q, data_par_d;
    logic                  accept;

    // Requests are only sampled at frame boundaries; STOP accepts to allow back-to-back frames.
    assign accept = DataValid && ((state_q == IDLE) || (state_q == STOP));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        data_par_d = data_par_q;
        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    shift_d    = PData;
                    par_en_d   = ParEn;
                    par_type_d = ParType;
                    data_par_d = ^PData;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == LAST_CNT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            data_par_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            data_par_q <= data_par_d;
        end
    end

    always_comb begin
        MuxSelection = 2'b01;
        case (state_q)
            START:   MuxSelection = 2'b00;
            DATA:    MuxSelection = 2'b10;
            PARITY:  MuxSelection = 2'b11;
            default: MuxSelection = 2'b01;
        endcase
    end

    assign SerData   = shift_q[0];
    assign ParityBit = data_par_q ^ par_type_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected per-cycle line states, a
// negedge monitor pops and compares them while Busy is high.
module tb_uart_tx_ctrl;

    typedef struct {
        logic [1:0] mux;
        logic       chk_ser;
        logic       ser;
        logic       par;
        logic       last;
    } item_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] PData;
    logic       DataValid;
    logic       ParEn;
    logic       ParType;
    logic [1:0] MuxSelection;
    logic       SerData;
    logic       ParityBit;
    logic       Busy;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  mon_en = 1'b0;
    logic  prev_last = 1'b1;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PData        (PData),
        .DataValid    (DataValid),
        .ParEn        (ParEn),
        .ParType      (ParType),
        .MuxSelection (MuxSelection),
        .SerData      (SerData),
        .ParityBit    (ParityBit),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_item(input logic [1:0] m, input logic cs, input logic s, input logic p,
                             input logic l);
        item_t it;
        it.mux = m; it.chk_ser = cs; it.ser = s; it.par = p; it.last = l;
        exp_q.push_back(it);
    endtask

    // p is the hand-computed parity for the vector; last=0 means another frame follows directly.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic p, input logic last);
        push_item(2'b00, 1'b0, 1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) push_item(2'b10, 1'b1, d[i], p, 1'b0);
        if (pe) push_item(2'b11, 1'b0, 1'b0, p, 1'b0);
        push_item(2'b01, 1'b0, 1'b0, p, last);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic p);
        @(posedge CLK); #1;
        PData = d; ParEn = pe; ParType = pt; DataValid = 1'b1;
        push_frame(d, pe, p, 1'b1);
        @(posedge CLK); #1;
        DataValid = 1'b0; PData = ~d; ParEn = ~pe; ParType = ~pt;
    endtask

    task automatic wait_done(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge CLK); #1;
            if (!Busy && exp_q.size() == 0) done = 1'b1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle with 0 pending",
                     name, Busy, exp_q.size());
        end
        repeat (2) @(posedge CLK);
    endtask

    always @(negedge CLK) begin
        item_t it;
        if (mon_en) begin
            if (Busy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_busy: mux=%b busy=1 expected idle", MuxSelection);
                end else begin
                    it = exp_q.pop_front();
                    check("mux", {6'd0, MuxSelection}, {6'd0, it.mux});
                    if (it.chk_ser) check("serdata", {7'd0, SerData}, {7'd0, it.ser});
                    check("parity", {7'd0, ParityBit}, {7'd0, it.par});
                    prev_last = it.last;
                end
            end else begin
                check("idle_mux", {6'd0, MuxSelection}, 8'h01);
                check("frame_gap", {7'd0, (!prev_last && exp_q.size() != 0)}, 8'h00);
            end
        end
    end

    initial begin
        RST = 1'b0; DataValid = 1'b0; PData = 8'h00; ParEn = 1'b0; ParType = 1'b0;
        #2;
        check("rst_mux", {6'd0, MuxSelection}, 8'h01);
        check("rst_busy", {7'd0, Busy}, 8'h00);
        check("rst_ser", {7'd0, SerData}, 8'h00);
        check("rst_par", {7'd0, ParityBit}, 8'h00);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        mon_en = 1'b1;

        send(8'hA5, 1'b1, 1'b0, 1'b0); wait_done("a5_par");
        send(8'h07, 1'b1, 1'b1, 1'b0); wait_done("07_odd");
        send(8'h07, 1'b1, 1'b0, 1'b1); wait_done("07_even");
        send(8'h3C, 1'b0, 1'b1, 1'b1); wait_done("3c_nopar");

        // Back-to-back: DataValid held, PData switched during the STOP cycle of frame 1.
        @(posedge CLK); #1;
        PData = 8'h11; ParEn = 1'b0; ParType = 1'b0; DataValid = 1'b1;
        push_frame(8'h11, 1'b0, 1'b0, 1'b0);
        push_frame(8'h22, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge CLK);
        #1 PData = 8'h22;
        @(posedge CLK); #1 DataValid = 1'b0;
        wait_done("b2b");

        // Request during DATA must be ignored.
        send(8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        PData = 8'hFF; DataValid = 1'b1;
        @(posedge CLK); #1 DataValid = 1'b0;
        wait_done("ignore_mid");

        // Mid-frame reset aborts asynchronously; first edge after release accepts a request.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK); #3;
        mon_en = 1'b0;
        RST = 1'b0;
        #1;
        check("abort_mux", {6'd0, MuxSelection}, 8'h01);
        check("abort_busy", {7'd0, Busy}, 8'h00);
        check("abort_ser", {7'd0, SerData}, 8'h00);
        check("abort_par", {7'd0, ParityBit}, 8'h00);
        exp_q.delete();
        prev_last = 1'b1;
        @(posedge CLK); #1;
        check("hold_mux", {6'd0, MuxSelection}, 8'h01);
        RST = 1'b1;
        PData = 8'h5A; ParEn = 1'b1; ParType = 1'b1; DataValid = 1'b1;
        push_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;
        @(posedge CLK); #1 DataValid = 1'b0;
        wait_done("post_reset");

        check("queue_empty", exp_q.size() == 0 ? 8'h00 : 8'h01, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: PData  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port: DataValid  input  1  PData valid / send request.
REQ-006 SHALL have port: ParEn  input  1  1 = insert parity bit.
REQ-007 SHALL have port: ParType  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port: MuxSelection  output  2  line-mux select: 00 start, 01 stop/idle, 10 data, 11 parity.
REQ-009 SHALL have port: SerData  output  1  current data bit.
REQ-010 SHALL have port: ParityBit  output  1  parity of the latched word.
REQ-011 SHALL have port: Busy  output  1  frame in progress.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY, STOP; MuxSelection decoded from state only: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-013 SHALL transmit one bit per CLK cycle; no baud divider.
REQ-014 SHALL accept a request only when DataValid=1 at an edge in state IDLE or STOP; DataValid in START/DATA/PARITY SHALL be ignored, with no effect on any register.
REQ-015 On acceptance SHALL, at the same edge, latch PData into a shift register, latch ParEn and ParType, and compute ParityBit = XOR-reduce(PData) XOR ParType; the next state SHALL be START.
REQ-016 Input changes on PData/ParEn/ParType after acceptance SHALL NOT affect the current frame.
REQ-017 START SHALL last exactly 1 cycle, then DATA.
REQ-018 DATA SHALL last exactly DATA_WIDTH cycles, LSB first; SerData SHALL equal shift-register bit 0, with the register shifted right once per DATA cycle; a bit counter 0..DATA_WIDTH-1 SHALL terminate DATA at count DATA_WIDTH-1.
REQ-019 After DATA: next state PARITY (1 cycle) if latched ParEn=1, else STOP.
REQ-020 STOP SHALL last 1 cycle; then START if a request is accepted in that cycle (back-to-back, no idle gap), else IDLE.
REQ-021 Busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.
REQ-022 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without, measured from the first START cycle to the last STOP cycle inclusive.
REQ-023 ParityBit SHALL hold its value until the next acceptance.
REQ-024 Bit counter SHALL reset to 0 on entry to DATA; no wrap beyond DATA_WIDTH-1.

Reset
REQ-025 RST=0 SHALL immediately, independent of CLK, force: state IDLE, MuxSelection=01, Busy=0, SerData=0, ParityBit=0, shift register 0, counter 0, latched ParEn/ParType 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the line returns to 01 (idle high) with no completion of remaining bits.
REQ-027 The first request SHALL be acceptable at the first rising edge after RST deasserts.

Verification
REQ-028 Reset: RST=0 while state is DATA -> MuxSelection=01 and Busy=0 asynchronously, before the next CLK edge.
REQ-029 PData=0xA5, ParEn=1, ParType=0, one-cycle DataValid -> MuxSelection sequence 00, 10×8, 11, 01; SerData 1,0,1,0,0,1,0,1; ParityBit=0; Busy high exactly 11 cycles.
REQ-030 PData=0x07, ParEn=1, ParType=1 -> ParityBit=0; with ParType=0 -> ParityBit=1.
REQ-031 PData=0x3C, ParEn=0 -> sequence 00, 10×8, 01, no 11 state; Busy high exactly 10 cycles.
REQ-032 DataValid held high continuously with PData 0x11 then 0x22 (changed in the STOP cycle) -> STOP of frame 1 is followed directly by START; frame 2 carries 0x22; no IDLE cycle between frames.
REQ-033 DataValid pulsed and PData changed to 0xFF during DATA of frame 0x00 -> frame 0x00 is transmitted unchanged; no second frame starts.
